m16_page_filler: RTL and testbench
==================================

Name: m16_page_filler

Overview:
- Upstream feeder of the M16 frame serializer's ping-pong word RAM (512 x 12: two pages of 256 words, page selected by address bit 8).
- The serializer reads the page named by its switch output and toggles that output every 256 words.
- This block fills the opposite page from a valid/ready 12-bit word source, optionally stamping word 0 with a header tag plus the current group number.
- It reports page completion and counts underruns.

Parameters:
- HDR_EN, 1, 1 = word 0 of each page is a generated header; 0 = all 256 words come from the source.
- HDR_TAG, 7'h5A, upper 7 bits of the header word.

Ports:
- clk  in  1  system clock (25.165824 MHz, same as serializer)
- reset  in  1  asynchronous, active-low reset
- iSwitch  in  1  serializer page-select; the page being read out
- iGrp  in  5  serializer group counter (grpOddity)
- iData  in  12  source word
- iValid  in  1  source word valid
- oReady  out  1  block accepts iData this cycle
- oWrEn  out  1  RAM write strobe
- oWrAddr  out  9  RAM write address {page, index}
- oWrData  out  12  RAM write data
- oBusy  out  1  fill in progress
- oPageDone  out  1  one-cycle pulse: page fully written
- oUnderCnt  out  8  saturating count of aborted fills

Behaviour:
- Reset (async, reset=0):
  - All outputs 0; state IDLE; index 0; swPrev 0; page 0; start flag set.
- Toggle detect:
  - swPrev <= iSwitch every cycle.
  - Toggle = iSwitch != swPrev, or start flag (first cycle after reset release; flag then clears).
- On toggle:
  - page <= ~iSwitch; index <= 0; state -> HDR if HDR_EN, else FILL; oBusy <= 1.
  - The header word captures iGrp in this same cycle.
- HDR (1 cycle):
  - oWrEn=1, oWrAddr={page,8'd0}, oWrData={HDR_TAG,iGrp captured}.
  - index <= 1; -> FILL.
  - oReady=0.
- FILL:
  - oReady=1 (combinational from state).
  - Handshake = iValid & oReady at a posedge. Next cycle: oWrEn=1, oWrAddr={page,index}, oWrData=iData; index <= index+1.
  - No handshake -> oWrEn=0 next cycle; no timeout; the source may stall indefinitely.
  - Handshake at index 255 -> DONE.
- DONE:
  - oPageDone=1 for exactly one cycle (the cycle of the final write); oBusy <= 0; oReady=0.
  - Then IDLE.
- IDLE:
  - oReady=0, oWrEn=0 (except the final-write cycle); wait for toggle.
- Toggle while in HDR or FILL before the 255-handshake (abort):
  - oUnderCnt <= oUnderCnt+1, saturating at 255.
  - A handshake accepted in the toggle cycle is still written next cycle to the old page.
  - The new fill then starts on the new page per the toggle rule. The old page is abandoned partially written; the serializer will read stale data from it.
- Toggle in the same cycle as the 255-handshake:
  - Counts as complete: no underrun, oPageDone pulses, new fill starts.
- Latency: handshake to RAM write = 1 clock; toggle to header write = 1 clock.
- Width rules:
  - index is 8-bit and never wraps within a fill (DONE at 255).
  - Page bit comes only from ~iSwitch latched at toggle; it never changes mid-fill.
- Timing budget: the serializer consumes 1 word per 96 clocks, i.e. 24576 clocks per page. Any source sustaining ≥1 word per 96 clocks never underruns.
- Reset mid-fill: everything is cleared immediately. On release, the start flag forces a fresh fill of page ~iSwitch.

Test Plan:
- Reset release with iSwitch=0, HDR_EN=1, iGrp=5'd3, iValid=1 continuously:
  - header write at addr 9'h100, data {7'h5A,5'd3} = 12'hB43.
  - Writes to 9'h101..9'h1FF with source data.
  - oPageDone pulses on the addr 9'h1FF write; oUnderCnt=0.
- Toggle iSwitch 0->1 after a completed fill, source incrementing 12'h000..:
  - writes go to addr 9'h000..9'h0FF;
  - oBusy is high from toggle+1 until the final write.
- Source stalls (iValid=0) after 100 words, then iSwitch toggles:
  - oUnderCnt increments 0->1; the new fill starts at the other page base; no further writes to the old page.
- iSwitch toggles in the same cycle as the 255th handshake:
  - last word written to old page;
  - oPageDone=1; oUnderCnt unchanged; next-cycle header on new page.
- 300 forced aborts:
  - oUnderCnt saturates at 8'd255.
- Assert reset mid-FILL at index 50:
  - all outputs 0 asynchronously;
  - after release, fill restarts from index 0 on page ~iSwitch with no stray writes.

Source files
------------

// File: rtl/m16_page_filler.sv
// m16_page_filler
// Fills the idle page of the M16 serializer's 512 x 12 ping-pong word RAM.
// The serializer reads page iSwitch; this block writes page ~iSwitch. Each
// iSwitch toggle starts a new fill. With HDR_EN the fill begins with a
// generated header word {HDR_TAG, iGrp}. The remaining words come from a
// valid/ready source.
//
// Ports
//   clk        system clock (shared with the serializer)
//   reset      asynchronous, active-low reset
//   iSwitch    serializer page select (page being read out)
//   iGrp       serializer group counter, stamped into the header word
//   iData      source word
//   iValid     source word valid
//   oReady     block accepts iData this cycle
//   oWrEn      RAM write strobe
//   oWrAddr    RAM write address {page, index}
//   oWrData    RAM write data
//   oBusy      fill in progress
//   oPageDone  one-cycle pulse on the cycle of the final write of a page
//   oUnderCnt  saturating count of fills aborted by an early toggle
//
// Handshake: a word transfers on a rising edge where iValid and oReady are
// both high. oReady depends only on the FSM state, never on iValid. The
// source holds iData stable while iValid is high and oReady is low. The
// accepted word reaches the RAM port one clock after the handshake.
module m16_page_filler #(
  parameter bit         HDR_EN  = 1'b1,
  parameter logic [6:0] HDR_TAG = 7'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iSwitch,
  input  logic [4:0]  iGrp,
  input  logic [11:0] iData,
  input  logic        iValid,
  output logic        oReady,
  output logic        oWrEn,
  output logic [8:0]  oWrAddr,
  output logic [11:0] oWrData,
  output logic        oBusy,
  output logic        oPageDone,
  output logic [7:0]  oUnderCnt
);

  // S_PEND: a toggle arrived together with an accepted word. That word
  // owns the RAM port this cycle, so the new header is written one cycle
  // later.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PEND,
    S_FILL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic        page_q, page_d;
  logic [4:0]  grp_q, grp_d;
  logic        sw_prev_q, sw_prev_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  under_q, under_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic [11:0] wr_data_q, wr_data_d;

  logic toggle;
  logic hs;
  logic last_hs;
  logic in_fill;

  assign in_fill = (state_q == S_FILL);
  assign toggle  = (iSwitch != sw_prev_q) || start_q;
  assign hs      = iValid && in_fill;
  assign last_hs = hs && (index_q == 8'hFF);

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    page_d    = page_q;
    grp_d     = grp_q;
    sw_prev_d = iSwitch;
    start_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    under_d   = under_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // An accepted word is always written next cycle to the page it was
    // accepted for, even when a toggle arrives in the same cycle.
    if (hs) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {page_q, index_q};
      wr_data_d = iData;
      if (!last_hs) begin
        index_d = index_q + 8'd1;
      end
    end
    if (last_hs) begin
      done_d = 1'b1;
    end

    if (toggle) begin
      // Leaving an unfinished page counts as an underrun. A toggle that
      // coincides with the final handshake counts as a completed page.
      if ((state_q == S_HDR || state_q == S_PEND || state_q == S_FILL) && !last_hs) begin
        under_d = (under_q != 8'hFF) ? under_q + 8'd1 : under_q;
      end
      page_d  = ~iSwitch;
      index_d = 8'd0;
      grp_d   = iGrp;
      busy_d  = 1'b1;
      if (HDR_EN) begin
        if (hs) begin
          state_d = S_PEND;
        end else begin
          state_d   = S_HDR;
          wr_en_d   = 1'b1;
          wr_addr_d = {~iSwitch, 8'h00};
          wr_data_d = {HDR_TAG, iGrp};
        end
      end else begin
        state_d = S_FILL;
      end
    end else begin
      case (state_q)
        S_PEND: begin
          state_d   = S_HDR;
          wr_en_d   = 1'b1;
          wr_addr_d = {page_q, 8'h00};
          wr_data_d = {HDR_TAG, grp_q};
        end
        S_HDR: begin
          index_d = 8'd1;
          state_d = S_FILL;
        end
        S_FILL: begin
          if (last_hs) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      index_q   <= 8'd0;
      page_q    <= 1'b0;
      grp_q     <= 5'd0;
      sw_prev_q <= 1'b0;
      start_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      under_q   <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 9'd0;
      wr_data_q <= 12'd0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      page_q    <= page_d;
      grp_q     <= grp_d;
      sw_prev_q <= sw_prev_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      under_q   <= under_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign oReady    = in_fill;
  assign oWrEn     = wr_en_q;
  assign oWrAddr   = wr_addr_q;
  assign oWrData   = wr_data_q;
  assign oBusy     = busy_q;
  assign oPageDone = done_q;
  assign oUnderCnt = under_q;

endmodule

// File: tb/tb_m16_page_filler.sv
// Testbench for m16_page_filler (HDR_EN=1, HDR_TAG=7'h5A).
// A page-level reference model predicts every RAM write. The model tracks
// the active fill, its page and next word index, and when the header is due.
// A monitor logs the writes that actually appear, and each scenario compares
// the two lists plus a few fixed values.
module tb_m16_page_filler;

  logic        clk;
  logic        reset;
  logic        iSwitch;
  logic [4:0]  iGrp;
  logic [11:0] iData;
  logic        iValid;
  logic        oReady;
  logic        oWrEn;
  logic [8:0]  oWrAddr;
  logic [11:0] oWrData;
  logic        oBusy;
  logic        oPageDone;
  logic [7:0]  oUnderCnt;

  m16_page_filler dut (
    .clk(clk), .reset(reset), .iSwitch(iSwitch), .iGrp(iGrp),
    .iData(iData), .iValid(iValid), .oReady(oReady), .oWrEn(oWrEn),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oBusy(oBusy),
    .oPageDone(oPageDone), .oUnderCnt(oUnderCnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Write entry packing: {page_done, addr[8:0], data[11:0]}
  logic [21:0] exp_q[$];
  logic [21:0] act_q[$];

  always @(negedge clk) begin
    if (reset === 1'b1 && (oWrEn || oPageDone)) act_q.push_back({oPageDone, oWrAddr, oWrData});
  end

  // ---------------- reference model ----------------
  bit          m_start, m_swprev, m_active, m_busy, m_page, m_hs, m_cur_done;
  int          m_wait, m_idx, m_under;
  bit          m_s2_v;
  logic [21:0] m_s2;

  function automatic void model_reset();
    m_start = 1; m_swprev = 0; m_active = 0; m_busy = 0; m_page = 0;
    m_hs = 0; m_cur_done = 0; m_wait = 0; m_idx = 0; m_under = 0;
    m_s2_v = 0; m_s2 = '0;
  endfunction

  // Advances one clock; pushes the write expected in the following cycle.
  function automatic void model_step(bit sw, logic [4:0] g, logic [11:0] d, bit v);
    bit tog, acc, nv, last, nb;
    logic [21:0] nx, hdr;
    tog = (sw != m_swprev) || m_start;
    m_start = 0; m_swprev = sw;
    if (m_wait > 0) m_wait--;
    acc = m_active && (m_wait == 0);
    m_hs = v && acc;
    nv = m_s2_v; nx = m_s2; m_s2_v = 0;
    last = 0;
    if (m_hs) begin
      last = (m_idx == 255);
      nv = 1;
      nx = {last, m_page, 8'(m_idx), d};
      if (last) m_active = 0;
      else m_idx++;
    end
    nb = m_cur_done ? 1'b0 : m_busy;
    if (tog) begin
      if (m_active) m_under = (m_under < 255) ? m_under + 1 : 255;
      m_active = 1; m_page = ~sw; m_idx = 1; nb = 1;
      hdr = {1'b0, ~sw, 8'h00, 7'h5A, g};
      if (nv) begin m_s2_v = 1; m_s2 = hdr; m_wait = 3; end
      else begin nv = 1; nx = hdr; m_wait = 2; end
    end
    m_busy = nb;
    m_cur_done = nv && nx[21] && !tog;
    if (nv) exp_q.push_back(nx);
  endfunction

  function automatic bit will_take_last();
    return m_active && (m_idx == 255) && (m_wait <= 1);
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit sw, input logic [4:0] g, input logic [11:0] d, input bit v);
    iSwitch = sw; iGrp = g; iData = d; iValid = v;
    model_step(sw, g, d, v);
    @(posedge clk); #1;
  endtask

  logic sw_now;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; iSwitch = 1'b0; iGrp = 5'd3; iData = 12'd0; iValid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 7;
    if (oReady !== 1'b0)     begin n_fail++; $display("FAIL rst_ready got %b want 0", oReady); end
    if (oWrEn !== 1'b0)      begin n_fail++; $display("FAIL rst_wren got %b want 0", oWrEn); end
    if (oWrAddr !== 9'd0)    begin n_fail++; $display("FAIL rst_addr got %h want 0", oWrAddr); end
    if (oWrData !== 12'd0)   begin n_fail++; $display("FAIL rst_data got %h want 0", oWrData); end
    if (oBusy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b want 0", oBusy); end
    if (oPageDone !== 1'b0)  begin n_fail++; $display("FAIL rst_done got %b want 0", oPageDone); end
    if (oUnderCnt !== 8'd0)  begin n_fail++; $display("FAIL rst_under got %0d want 0", oUnderCnt); end
    model_reset();
    exp_q.delete(); act_q.delete();
    reset = 1'b1;
    sw_now = 1'b0;
    for (int n = 0; n < 270; n++) drive_cycle(sw_now, 5'd3, 12'($urandom), 1'b1);
    @(negedge clk); #1;
    n_checks++;
    if (act_q.size() != 256) begin n_fail++; $display("FAIL first_fill_count got %0d want 256", act_q.size()); end
    if (act_q.size() > 0) begin
      n_checks++;
      if (act_q[0] !== {1'b0, 9'h100, 12'hB43}) begin n_fail++; $display("FAIL first_header got %h want %h", act_q[0], {1'b0, 9'h100, 12'hB43}); end
    end
    if (act_q.size() == 256) begin
      n_checks++;
      if (act_q[255][21:12] !== {1'b1, 9'h1FF}) begin n_fail++; $display("FAIL first_last got %h want done+1FF", act_q[255][21:12]); end
    end
    n_checks++;
    if (oUnderCnt !== 8'd0) begin n_fail++; $display("FAIL first_under got %0d want 0", oUnderCnt); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size()) begin n_fail++; $display("FAIL first_wr[%0d] got none want %h", i, exp_q[i]); end
      else if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL first_wr[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_toggle();
    logic [11:0] d_cnt;
    logic [4:0]  g;
    int          busy_bad;
    d_cnt = 12'h000; g = 5'($urandom_range(0, 31)); busy_bad = 0;
    sw_now = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      drive_cycle(sw_now, g, d_cnt, ($urandom_range(0, 3) != 0));
      if (m_hs) d_cnt++;
      n_checks++;
      if (oBusy !== m_busy) begin n_fail++; $display("FAIL toggle_busy cyc %0d got %b want %b", n, oBusy, m_busy); end
      if (oWrEn === 1'b1 && oBusy !== 1'b1) busy_bad++;
      if (!m_busy) break;
    end
    n_checks++;
    if (m_busy) begin n_fail++; $display("FAIL toggle_timeout got busy want idle"); end
    drive_cycle(sw_now, g, 12'd0, 1'b0);
    @(negedge clk); #1;
    n_checks++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL toggle_busy_on_write got %0d low cycles want 0", busy_bad); end
    n_checks++;
    if (act_q.size() != 256) begin n_fail++; $display("FAIL toggle_count got %0d want 256", act_q.size()); end
    if (act_q.size() == 256) begin
      n_checks += 2;
      if (act_q[0] !== {1'b0, 9'h000, 7'h5A, g}) begin n_fail++; $display("FAIL toggle_header got %h want %h", act_q[0], {1'b0, 9'h000, 7'h5A, g}); end
      if (act_q[255] !== {1'b1, 9'h0FF, 12'h0FE}) begin n_fail++; $display("FAIL toggle_last got %h want %h", act_q[255], {1'b1, 9'h0FF, 12'h0FE}); end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size()) begin n_fail++; $display("FAIL toggle_wr[%0d] got none want %h", i, exp_q[i]); end
      else if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_wr[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_underrun();
    logic [4:0] g;
    int         k, bad;
    g = 5'($urandom_range(0, 31)); bad = 0;
    sw_now = 1'b0;
    for (int n = 0; n < 500 && m_idx != 101; n++) drive_cycle(sw_now, g, 12'($urandom), 1'b1);
    n_checks++;
    if (m_idx != 101) begin n_fail++; $display("FAIL under_fill_timeout got idx %0d want 101", m_idx); end
    for (int n = 0; n < 20; n++) drive_cycle(sw_now, g, 12'($urandom), 1'b0);
    n_checks++;
    if (oUnderCnt !== 8'd0) begin n_fail++; $display("FAIL under_before got %0d want 0", oUnderCnt); end
    sw_now = 1'b1;
    drive_cycle(sw_now, g, 12'd0, 1'b0);
    k = exp_q.size();
    drive_cycle(sw_now, g, 12'd0, 1'b0);
    n_checks += 2;
    if (oUnderCnt !== 8'd1) begin n_fail++; $display("FAIL under_after got %0d want 1", oUnderCnt); end
    if (oUnderCnt !== 8'(m_under)) begin n_fail++; $display("FAIL under_model got %0d want %0d", oUnderCnt, m_under); end
    for (int n = 0; n < 3000 && m_busy; n++) drive_cycle(sw_now, g, 12'($urandom), ($urandom_range(0, 1) == 1));
    n_checks++;
    if (m_busy) begin n_fail++; $display("FAIL under_refill_timeout got busy want idle"); end
    drive_cycle(sw_now, g, 12'd0, 1'b0);
    @(negedge clk); #1;
    for (int i = k - 1; i < act_q.size(); i++) if (act_q[i][20] !== 1'b0) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL under_old_page_writes got %0d want 0", bad); end
    n_checks++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL under_count got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size()) begin n_fail++; $display("FAIL under_wr[%0d] got none want %h", i, exp_q[i]); end
      else if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL under_wr[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [4:0] g, g2;
    int         u0;
    g = 5'($urandom_range(0, 31)); g2 = 5'($urandom_range(0, 31));
    sw_now = 1'b0;
    for (int n = 0; n < 1000 && !(n > 0 && will_take_last()); n++) drive_cycle(sw_now, g, 12'($urandom), 1'b1);
    n_checks++;
    if (!will_take_last()) begin n_fail++; $display("FAIL b2b_timeout got idx %0d want 255", m_idx); end
    u0 = m_under;
    sw_now = 1'b1;
    drive_cycle(sw_now, g2, 12'($urandom), 1'b1);
    n_checks += 4;
    if (oPageDone !== 1'b1)        begin n_fail++; $display("FAIL b2b_done got %b want 1", oPageDone); end
    if (oWrEn !== 1'b1)            begin n_fail++; $display("FAIL b2b_last_wren got %b want 1", oWrEn); end
    if (oWrAddr !== 9'h1FF)        begin n_fail++; $display("FAIL b2b_last_addr got %h want 1FF", oWrAddr); end
    if (oUnderCnt !== 8'(u0))      begin n_fail++; $display("FAIL b2b_under got %0d want %0d", oUnderCnt, u0); end
    drive_cycle(sw_now, g2, 12'($urandom), 1'b1);
    n_checks += 4;
    if (oWrEn !== 1'b1)                begin n_fail++; $display("FAIL b2b_hdr_wren got %b want 1", oWrEn); end
    if (oWrAddr !== 9'h000)            begin n_fail++; $display("FAIL b2b_hdr_addr got %h want 000", oWrAddr); end
    if (oWrData !== {7'h5A, g2})       begin n_fail++; $display("FAIL b2b_hdr_data got %h want %h", oWrData, {7'h5A, g2}); end
    if (oPageDone !== 1'b0)            begin n_fail++; $display("FAIL b2b_done_width got %b want 0", oPageDone); end
    for (int n = 0; n < 10; n++) drive_cycle(sw_now, g2, 12'($urandom), ($urandom_range(0, 1) == 1));
    @(negedge clk); #1;
    n_checks++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size()) begin n_fail++; $display("FAIL b2b_wr[%0d] got none want %h", i, exp_q[i]); end
      else if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_wr[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 300; n++) begin
      sw_now = ~sw_now;
      drive_cycle(sw_now, 5'($urandom_range(0, 31)), 12'd0, 1'b0);
      drive_cycle(sw_now, 5'd0, 12'd0, 1'b0);
    end
    n_checks += 2;
    if (oUnderCnt !== 8'd255) begin n_fail++; $display("FAIL sat_under got %0d want 255", oUnderCnt); end
    if (oUnderCnt !== 8'(m_under)) begin n_fail++; $display("FAIL sat_model got %0d want %0d", oUnderCnt, m_under); end
    @(negedge clk); #1;
    n_checks++;
    if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size()) begin n_fail++; $display("FAIL sat_wr[%0d] got none want %h", i, exp_q[i]); end
      else if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_wr[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [4:0] g;
    g = 5'($urandom_range(0, 31));
    for (int n = 0; n < 500 && m_idx != 50; n++) drive_cycle(sw_now, g, 12'($urandom), 1'b1);
    n_checks++;
    if (m_idx != 50) begin n_fail++; $display("FAIL rmid_fill_timeout got idx %0d want 50", m_idx); end
    @(negedge clk); #1;
    exp_q.delete(); act_q.delete();
    reset = 1'b0;
    #1;
    n_checks += 7;
    if (oReady !== 1'b0)     begin n_fail++; $display("FAIL rmid_ready got %b want 0", oReady); end
    if (oWrEn !== 1'b0)      begin n_fail++; $display("FAIL rmid_wren got %b want 0", oWrEn); end
    if (oWrAddr !== 9'd0)    begin n_fail++; $display("FAIL rmid_addr got %h want 0", oWrAddr); end
    if (oWrData !== 12'd0)   begin n_fail++; $display("FAIL rmid_data got %h want 0", oWrData); end
    if (oBusy !== 1'b0)      begin n_fail++; $display("FAIL rmid_busy got %b want 0", oBusy); end
    if (oPageDone !== 1'b0)  begin n_fail++; $display("FAIL rmid_done got %b want 0", oPageDone); end
    if (oUnderCnt !== 8'd0)  begin n_fail++; $display("FAIL rmid_under got %0d want 0", oUnderCnt); end
    repeat (3) @(negedge clk);
    model_reset();
    sw_now = 1'($urandom_range(0, 1));
    reset = 1'b1;
    for (int n = 0; n < 3000 && (n == 0 || m_busy); n++) drive_cycle(sw_now, g, 12'($urandom), ($urandom_range(0, 3) != 0));
    n_checks++;
    if (m_busy) begin n_fail++; $display("FAIL rmid_timeout got busy want idle"); end
    drive_cycle(sw_now, g, 12'd0, 1'b0);
    @(negedge clk); #1;
    n_checks++;
    if (act_q.size() != 256) begin n_fail++; $display("FAIL rmid_count got %0d want 256", act_q.size()); end
    if (act_q.size() > 0) begin
      n_checks++;
      if (act_q[0] !== {1'b0, ~sw_now, 8'h00, 7'h5A, g}) begin n_fail++; $display("FAIL rmid_header got %h want %h", act_q[0], {1'b0, ~sw_now, 8'h00, 7'h5A, g}); end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= act_q.size()) begin n_fail++; $display("FAIL rmid_wr[%0d] got none want %h", i, exp_q[i]); end
      else if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_wr[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_toggle();
    test_underrun();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
